pll_phase_ctrl: RTL and testbench

Sequencer and supervisor for the ECP5 EHXPLLL that generates the 12 MHz audio clock. It runs on the 25 MHz board reference clock and drives the PLL reset and dynamic phase-shift pins: PHASESEL, PHASEDIR, PHASESTEP and PHASELOADREG. It debounces PLL lock, re-resets the PLL on sustained lock loss, and holds the downstream logic reset until lock has been stable. Firmware or a calibration FSM requests N phase steps on one output through a valid/ready handshake.

---
 rtl/pll_ctrl_pkg.sv | 34 +++
 rtl/sync_ff2.sv | 25 ++
 rtl/pll_phase_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL phase-shift sequencer.
//   - pll_state_t : sequencer state encoding
//   - SEL_*       : PHASESEL output-select codes
//   - DEF_*       : default timing parameters, in reference-clock cycles
//   - max_int     : helper used to size the shared timer
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_IDLE      = 3'd2,
      ST_SETUP     = 3'd3,
      ST_STEP_LO   = 3'd4,
      ST_STEP_HI   = 3'd5,
      ST_DONE      = 3'd6
   } pll_state_t;

   localparam logic [1:0] SEL_OP  = 2'd0;
   localparam logic [1:0] SEL_OS  = 2'd1;
   localparam logic [1:0] SEL_OS2 = 2'd2;
   localparam logic [1:0] SEL_OS3 = 2'd3;

   localparam int DEF_RST_CYCLES  = 16;
   localparam int DEF_LOCK_STABLE = 128;
   localparam int DEF_LOSS_FILTER = 4;
   localparam int DEF_SETUP       = 2;
   localparam int DEF_PULSE       = 4;
   localparam int DEF_SETTLE      = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a single asynchronous level signal.
//   clk_in   : destination clock
//   rst_in_n : asynchronous active-low reset, both flops clear to 0
//   d        : asynchronous input
//   q        : synchronized output, two cycles of latency
module sync_ff2 (
   input  logic clk_in,
   input  logic rst_in_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequencer and supervisor for the ECP5 EHXPLLL audio-clock PLL.
// Pulses the PLL reset, waits for a stable lock before releasing the
// downstream logic reset, re-resets the PLL on a sustained lock loss, and
// executes N-step dynamic phase shifts requested over a valid/ready handshake.
//   clk_in, rst_in_n        : 25 MHz reference clock, async active-low reset
//   pll_lock                : PLL LOCK (asynchronous)
//   pll_rst                 : PLL RST, active-high
//   pll_phasesel/dir/step   : dynamic phase-shift controls (PHASESTEP idles high)
//   pll_phaseloadreg        : tied high
//   rst_out                 : downstream logic reset, active-high
//   req_valid/ready/sel/dir/steps : phase-step request handshake
//   done_valid, done_err    : completion pulse, err = aborted by lock loss
//   relock_cnt              : saturating count of lock-loss re-resets
module pll_phase_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int RST_CYCLES  = DEF_RST_CYCLES,
   parameter int LOCK_STABLE = DEF_LOCK_STABLE,
   parameter int LOSS_FILTER = DEF_LOSS_FILTER,
   parameter int SETUP       = DEF_SETUP,
   parameter int PULSE       = DEF_PULSE,
   parameter int SETTLE      = DEF_SETTLE
) (
   input  logic       clk_in,
   input  logic       rst_in_n,
   input  logic       pll_lock,
   output logic       pll_rst,
   output logic [1:0] pll_phasesel,
   output logic       pll_phasedir,
   output logic       pll_phasestep,
   output logic       pll_phaseloadreg,
   output logic       rst_out,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_sel,
   input  logic       req_dir,
   input  logic [7:0] req_steps,
   output logic       done_valid,
   output logic       done_err,
   output logic [7:0] relock_cnt
);

   localparam int TMR_MAX = max_int(max_int(RST_CYCLES, LOCK_STABLE),
                                    max_int(max_int(SETUP, PULSE), SETTLE));
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int LOSS_W  = $clog2(LOSS_FILTER + 1);

   localparam logic [TMR_W-1:0]  RST_LAST    = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0]  STABLE_LAST = TMR_W'(LOCK_STABLE - 1);
   localparam logic [TMR_W-1:0]  SETUP_LAST  = TMR_W'(SETUP - 1);
   localparam logic [TMR_W-1:0]  PULSE_LAST  = TMR_W'(PULSE - 1);
   localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE - 1);
   localparam logic [LOSS_W-1:0] LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);

   pll_state_t        state;
   logic [TMR_W-1:0]  tmr;
   logic [LOSS_W-1:0] loss_cnt;
   logic [7:0]        remaining;
   logic              lock_s;
   logic              supervise;
   logic              loss_track;
   logic              loss_hit;
   logic              in_flight;

   sync_ff2 u_lock_sync (
      .clk_in   (clk_in),
      .rst_in_n (rst_in_n),
      .d        (pll_lock),
      .q        (lock_s)
   );

   assign pll_phaseloadreg = 1'b1;

   // Lock loss may abort from IDLE through STEP_HI. The unlocked-run counter
   // also runs through DONE so a loss straddling DONE fires in the next IDLE.
   assign supervise  = (state == ST_IDLE) || (state == ST_SETUP) ||
                       (state == ST_STEP_LO) || (state == ST_STEP_HI);
   assign loss_track = supervise || (state == ST_DONE);
   assign loss_hit   = !lock_s && (loss_cnt == LOSS_LAST);
   // A handshake coinciding with the loss counts as accepted, so it is reported.
   assign in_flight  = (state == ST_SETUP) || (state == ST_STEP_LO) ||
                       (state == ST_STEP_HI) || ((state == ST_IDLE) && req_valid);

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state         <= ST_PLL_RST;
         tmr           <= '0;
         loss_cnt      <= '0;
         remaining     <= 8'd0;
         pll_rst       <= 1'b1;
         pll_phasesel  <= SEL_OP;
         pll_phasedir  <= 1'b1;
         pll_phasestep <= 1'b1;
         rst_out       <= 1'b1;
         req_ready     <= 1'b0;
         done_valid    <= 1'b0;
         done_err      <= 1'b0;
         relock_cnt    <= 8'd0;
      end else begin
         done_valid <= 1'b0;
         done_err   <= 1'b0;

         if (supervise && loss_hit) begin
            state         <= ST_PLL_RST;
            tmr           <= '0;
            loss_cnt      <= '0;
            pll_rst       <= 1'b1;
            pll_phasestep <= 1'b1;
            rst_out       <= 1'b1;
            req_ready     <= 1'b0;
            if (relock_cnt != 8'hFF) begin
               relock_cnt <= relock_cnt + 8'd1;
            end
            if (in_flight) begin
               done_valid <= 1'b1;
               done_err   <= 1'b1;
            end
         end else begin
            if (!loss_track || lock_s) begin
               loss_cnt <= '0;
            end else if (loss_cnt != LOSS_LAST) begin
               loss_cnt <= loss_cnt + 1'b1;
            end

            case (state)
               ST_PLL_RST: begin
                  if (tmr == RST_LAST) begin
                     pll_rst <= 1'b0;
                     tmr     <= '0;
                     state   <= ST_WAIT_LOCK;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end

               ST_WAIT_LOCK: begin
                  if (!lock_s) begin
                     tmr <= '0;
                  end else if (tmr == STABLE_LAST) begin
                     tmr       <= '0;
                     rst_out   <= 1'b0;
                     req_ready <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end

               ST_IDLE: begin
                  if (req_valid && req_ready) begin
                     req_ready <= 1'b0;
                     remaining <= req_steps;
                     if (req_steps == 8'd0) begin
                        done_valid <= 1'b1;
                        state      <= ST_DONE;
                     end else begin
                        pll_phasesel <= req_sel;
                        pll_phasedir <= req_dir;
                        tmr          <= '0;
                        state        <= ST_SETUP;
                     end
                  end
               end

               ST_SETUP: begin
                  if (tmr == SETUP_LAST) begin
                     pll_phasestep <= 1'b0;
                     tmr           <= '0;
                     state         <= ST_STEP_LO;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end

               ST_STEP_LO: begin
                  if (tmr == PULSE_LAST) begin
                     pll_phasestep <= 1'b1;
                     tmr           <= '0;
                     state         <= ST_STEP_HI;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end

               ST_STEP_HI: begin
                  if (tmr == SETTLE_LAST) begin
                     tmr       <= '0;
                     remaining <= remaining - 8'd1;
                     if (remaining == 8'd1) begin
                        done_valid <= 1'b1;
                        state      <= ST_DONE;
                     end else begin
                        pll_phasestep <= 1'b0;
                        state         <= ST_STEP_LO;
                     end
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end

               ST_DONE: begin
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end

               default: begin
                  pll_rst <= 1'b1;
                  tmr     <= '0;
                  state   <= ST_PLL_RST;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with default parameters.
module tb_pll_phase_ctrl;
   import pll_ctrl_pkg::*;

   logic       clk_in = 1'b0;
   logic       rst_in_n;
   logic       pll_lock;
   logic       pll_rst;
   logic [1:0] pll_phasesel;
   logic       pll_phasedir;
   logic       pll_phasestep;
   logic       pll_phaseloadreg;
   logic       rst_out;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_sel;
   logic       req_dir;
   logic [7:0] req_steps;
   logic       done_valid;
   logic       done_err;
   logic [7:0] relock_cnt;

   int checks = 0;
   int errors = 0;

   // pll_rst, sel, dir, step, loadreg, rst_out, ready, done_valid, done_err, relock_cnt
   localparam logic [17:0] RST_VEC = 18'b1_00_1_1_1_1_0_0_0_00000000;
   logic [17:0] out_vec;
   assign out_vec = {pll_rst, pll_phasesel, pll_phasedir, pll_phasestep, pll_phaseloadreg,
                     rst_out, req_ready, done_valid, done_err, relock_cnt};

   pll_phase_ctrl dut (
      .clk_in           (clk_in),
      .rst_in_n         (rst_in_n),
      .pll_lock         (pll_lock),
      .pll_rst          (pll_rst),
      .pll_phasesel     (pll_phasesel),
      .pll_phasedir     (pll_phasedir),
      .pll_phasestep    (pll_phasestep),
      .pll_phaseloadreg (pll_phaseloadreg),
      .rst_out          (rst_out),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_sel          (req_sel),
      .req_dir          (req_dir),
      .req_steps        (req_steps),
      .done_valid       (done_valid),
      .done_err         (done_err),
      .relock_cnt       (relock_cnt)
   );

   always #20 clk_in = ~clk_in;

   initial begin
      #(40 * 20000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Waits (bounded) for req_ready, then holds req_valid for exactly one edge.
   // After return the bench sits in cycle T+1. Request fields are then scrambled.
   task automatic send_req(input logic [1:0] sel, input logic dir, input logic [7:0] steps);
      for (int i = 0; i < 300 && !req_ready; i++) tick();
      req_sel   = sel;
      req_dir   = dir;
      req_steps = steps;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      req_sel   = ~sel;
      req_dir   = ~dir;
      req_steps = 8'd9;
   endtask

   task automatic test_reset();
      rst_in_n  = 1'b0;
      pll_lock  = 1'b0;
      req_valid = 1'b0;
      req_sel   = 2'd0;
      req_dir   = 1'b0;
      req_steps = 8'd0;
      repeat (3) tick();
      checks++;
      if (out_vec !== RST_VEC) begin
         errors++;
         $display("FAIL reset_values: got %b expected %b", out_vec, RST_VEC);
      end
   endtask

   task automatic test_powerup();
      int n;
      rst_in_n = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n++;
         if (!pll_rst) break;
      end
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL pll_rst_width: got %0d cycles expected 16", n);
      end
      repeat (50) tick();
      checks++;
      if (rst_out !== 1'b1) begin
         errors++;
         $display("FAIL rst_out_before_lock: got %b expected 1", rst_out);
      end
      pll_lock = 1'b1;
      n = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         n++;
         if (!rst_out) break;
      end
      checks++;
      if (n !== 130) begin
         errors++;
         $display("FAIL lock_to_rst_out: got %0d cycles expected 130", n);
      end
      checks++;
      if (req_ready !== 1'b1 || relock_cnt !== 8'd0) begin
         errors++;
         $display("FAIL idle_after_lock: got ready=%b relock=%0d expected ready=1 relock=0",
                  req_ready, relock_cnt);
      end
   endtask

   task automatic test_steps3();
      int falls, lows, dv_cyc, dv_cnt, sel_bad, ready_bad;
      int fall_at[3];
      logic prev, derr_at_dv, ready40;
      falls = 0; lows = 0; dv_cyc = -1; dv_cnt = 0; sel_bad = 0; ready_bad = 0;
      fall_at[0] = -1; fall_at[1] = -1; fall_at[2] = -1;
      prev = 1'b1; derr_at_dv = 1'bx; ready40 = 1'b0;
      send_req(SEL_OS, 1'b0, 8'd3);
      for (int k = 1; k <= 45; k++) begin
         if (k <= 39 && (pll_phasesel !== SEL_OS || pll_phasedir !== 1'b0)) sel_bad++;
         if (k <= 39 && req_ready !== 1'b0) ready_bad++;
         if (k == 40) ready40 = req_ready;
         if (pll_phasestep === 1'b0) lows++;
         if (prev === 1'b1 && pll_phasestep === 1'b0) begin
            if (falls < 3) fall_at[falls] = k;
            falls++;
         end
         prev = pll_phasestep;
         if (done_valid === 1'b1) begin
            dv_cnt++;
            if (dv_cyc < 0) begin
               dv_cyc = k;
               derr_at_dv = done_err;
            end
         end
         tick();
      end
      checks++;
      if (sel_bad !== 0) begin
         errors++;
         $display("FAIL s3_sel_dir: got %0d bad cycles expected 0", sel_bad);
      end
      checks++;
      if (falls !== 3 || lows !== 12) begin
         errors++;
         $display("FAIL s3_pulses: got falls=%0d lows=%0d expected falls=3 lows=12", falls, lows);
      end
      checks++;
      if (fall_at[0] !== 3 || fall_at[1] !== 15 || fall_at[2] !== 27) begin
         errors++;
         $display("FAIL s3_fall_cycles: got %0d,%0d,%0d expected 3,15,27",
                  fall_at[0], fall_at[1], fall_at[2]);
      end
      checks++;
      if (dv_cyc !== 39 || dv_cnt !== 1 || derr_at_dv !== 1'b0) begin
         errors++;
         $display("FAIL s3_done: got cycle=%0d count=%0d err=%b expected cycle=39 count=1 err=0",
                  dv_cyc, dv_cnt, derr_at_dv);
      end
      checks++;
      if (ready_bad !== 0 || ready40 !== 1'b1) begin
         errors++;
         $display("FAIL s3_ready: got busy_ready=%0d ready40=%b expected 0 and 1",
                  ready_bad, ready40);
      end
   endtask

   task automatic test_steps0();
      int lows;
      logic dv1, de1, rdy2;
      lows = 0;
      send_req(SEL_OS3, 1'b1, 8'd0);
      dv1 = done_valid;
      de1 = done_err;
      for (int k = 1; k <= 6; k++) begin
         if (k == 2) rdy2 = req_ready;
         if (pll_phasestep !== 1'b1) lows++;
         tick();
      end
      checks++;
      if (dv1 !== 1'b1 || de1 !== 1'b0) begin
         errors++;
         $display("FAIL s0_done: got valid=%b err=%b expected valid=1 err=0", dv1, de1);
      end
      checks++;
      if (lows !== 0 || rdy2 !== 1'b1) begin
         errors++;
         $display("FAIL s0_quiet: got lows=%0d ready2=%b expected lows=0 ready2=1", lows, rdy2);
      end
   endtask

   task automatic test_glitch3();
      int dv_cyc, falls, rst_bad;
      logic prev, derr_at_dv;
      dv_cyc = -1; falls = 0; rst_bad = 0; prev = 1'b1; derr_at_dv = 1'bx;
      send_req(SEL_OS2, 1'b1, 8'd2);
      for (int k = 1; k <= 35; k++) begin
         if (k == 5) pll_lock = 1'b0;
         if (k == 8) pll_lock = 1'b1;
         if (rst_out !== 1'b0) rst_bad++;
         if (prev === 1'b1 && pll_phasestep === 1'b0) falls++;
         prev = pll_phasestep;
         if (done_valid === 1'b1 && dv_cyc < 0) begin
            dv_cyc = k;
            derr_at_dv = done_err;
         end
         tick();
      end
      checks++;
      if (dv_cyc !== 27 || derr_at_dv !== 1'b0 || falls !== 2) begin
         errors++;
         $display("FAIL glitch_done: got cycle=%0d err=%b falls=%0d expected cycle=27 err=0 falls=2",
                  dv_cyc, derr_at_dv, falls);
      end
      checks++;
      if (relock_cnt !== 8'd0 || rst_bad !== 0) begin
         errors++;
         $display("FAIL glitch_ignored: got relock=%0d rst_out_high=%0d expected 0 and 0",
                  relock_cnt, rst_bad);
      end
   endtask

   task automatic test_abort();
      int dv_cyc, dv_cnt, rst_hi;
      logic [4:0] at_dv;
      dv_cyc = -1; dv_cnt = 0; rst_hi = 0; at_dv = 5'bx;
      send_req(SEL_OP, 1'b1, 8'd3);
      for (int k = 1; k <= 40; k++) begin
         if (k == 16) pll_lock = 1'b0;
         if (k == 20) pll_lock = 1'b1;
         if (pll_rst === 1'b1) rst_hi++;
         if (done_valid === 1'b1) begin
            dv_cnt++;
            if (dv_cyc < 0) begin
               dv_cyc = k;
               at_dv = {done_err, rst_out, pll_phasestep, pll_rst, (relock_cnt == 8'd1)};
            end
         end
         tick();
      end
      checks++;
      if (dv_cyc !== 22 || dv_cnt !== 1) begin
         errors++;
         $display("FAIL abort_done_cycle: got cycle=%0d count=%0d expected cycle=22 count=1",
                  dv_cyc, dv_cnt);
      end
      checks++;
      if (at_dv !== 5'b11111) begin
         errors++;
         $display("FAIL abort_state: got err,rst_out,step,pll_rst,relock1=%b expected 11111", at_dv);
      end
      checks++;
      if (rst_hi !== 16) begin
         errors++;
         $display("FAIL abort_pll_rst_width: got %0d expected 16", rst_hi);
      end
      for (int i = 0; i < 300 && !req_ready; i++) tick();
      checks++;
      if (req_ready !== 1'b1 || rst_out !== 1'b0 || relock_cnt !== 8'd1) begin
         errors++;
         $display("FAIL abort_recover: got ready=%b rst_out=%b relock=%0d expected 1,0,1",
                  req_ready, rst_out, relock_cnt);
      end
   endtask

   task automatic test_async_reset();
      int dv_seen;
      logic step4;
      dv_seen = 0;
      send_req(SEL_OS, 1'b0, 8'd2);
      repeat (3) tick();
      step4 = pll_phasestep;
      checks++;
      if (step4 !== 1'b0) begin
         errors++;
         $display("FAIL areset_precond: got step=%b expected 0", step4);
      end
      #5;
      rst_in_n = 1'b0;
      #1;
      checks++;
      if (out_vec !== RST_VEC) begin
         errors++;
         $display("FAIL areset_immediate: got %b expected %b", out_vec, RST_VEC);
      end
      for (int k = 0; k < 4; k++) begin
         if (done_valid !== 1'b0) dv_seen++;
         tick();
      end
      checks++;
      if (dv_seen !== 0 || out_vec !== RST_VEC) begin
         errors++;
         $display("FAIL areset_hold: got done_cycles=%0d vec=%b expected 0 and %b",
                  dv_seen, out_vec, RST_VEC);
      end
      rst_in_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_steps3();
      test_steps0();
      test_glitch3();
      test_abort();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
